// File: rtl/neuron_operand_loader.sv
// Byte-stream operand loader and result capture for a single neuron instance.
// One frame (inputs, weights, bias) yields one captured neuron result.
module neuron_operand_loader #(
    parameter int unsigned INPUT_DATA_SIZE = 4,
    parameter int unsigned RESOLUTION      = 8,
    parameter int unsigned SETTLE_CYCLES   = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic signed [RESOLUTION-1:0]            s_data,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    output logic [RESOLUTION*INPUT_DATA_SIZE-1:0]   input_data,
    output logic [RESOLUTION*INPUT_DATA_SIZE-1:0]   weight,
    output logic signed [RESOLUTION-1:0]            bias,
    output logic                                    operands_valid,
    input  logic signed [RESOLUTION-1:0]            neuron_result,
    output logic signed [RESOLUTION-1:0]            result_data,
    output logic                                    result_valid,
    input  logic                                    result_ready
);

    localparam int unsigned CNT_W = $clog2(INPUT_DATA_SIZE) + 1;
    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INPUT_DATA_SIZE - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        LOAD_IN,
        LOAD_W,
        LOAD_B,
        WAIT,
        RESULT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [SET_W-1:0]   settle;
    logic [SET_W-1:0]   settle_next;
    logic               hs;
    logic               wr_in;
    logic               wr_w;
    logic               wr_b;
    logic               capture;
    logic               res_done;

    // Next-state, counter and datapath-strobe decode
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        settle_next = settle;
        hs          = s_valid && s_ready;
        wr_in       = 1'b0;
        wr_w        = 1'b0;
        wr_b        = 1'b0;
        capture     = 1'b0;
        res_done    = 1'b0;
        case (state)
            LOAD_IN: begin
                if (hs) begin
                    wr_in = 1'b1;
                    if (cnt == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = LOAD_W;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            LOAD_W: begin
                if (hs) begin
                    wr_w = 1'b1;
                    if (cnt == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = LOAD_B;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            LOAD_B: begin
                if (hs) begin
                    wr_b        = 1'b1;
                    settle_next = '0;
                    state_next  = WAIT;
                end
            end
            WAIT: begin
                settle_next = settle + SET_W'(1);
                if (settle == SET_LAST) begin
                    capture    = 1'b1;
                    state_next = RESULT;
                end
            end
            RESULT: begin
                if (result_ready) begin
                    res_done   = 1'b1;
                    state_next = LOAD_IN;
                end
            end
            default: begin
                state_next = LOAD_IN;
            end
        endcase
    end

    // State, counters and the registered stream-ready flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= LOAD_IN;
            cnt     <= '0;
            settle  <= '0;
            s_ready <= 1'b1;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            settle  <= settle_next;
            s_ready <= (state_next == LOAD_IN) || (state_next == LOAD_W) ||
                       (state_next == LOAD_B);
        end
    end

    // Operand vectors, bias and result capture registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            input_data     <= '0;
            weight         <= '0;
            bias           <= '0;
            operands_valid <= 1'b0;
            result_data    <= '0;
            result_valid   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < INPUT_DATA_SIZE; i++) begin
                if (wr_in && (cnt == CNT_W'(i))) begin
                    input_data[i*RESOLUTION +: RESOLUTION] <= s_data;
                end
                if (wr_w && (cnt == CNT_W'(i))) begin
                    weight[i*RESOLUTION +: RESOLUTION] <= s_data;
                end
            end
            if (wr_in) begin
                operands_valid <= 1'b0;
            end
            if (wr_b) begin
                bias           <= s_data;
                operands_valid <= 1'b1;
            end
            if (capture) begin
                result_data  <= neuron_result;
                result_valid <= 1'b1;
            end
            if (res_done) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/neuron_operand_loader.md
Name: neuron_operand_loader

Overview:
- Feeds one `neuron` instance. Accepts a byte stream over a valid/ready handshake and assembles from it the flattened `input_data` vector, the flattened `weight` vector and the `bias`, which drive the neuron.
- Waits a fixed settle time, captures the neuron's registered `output_neuron` value and returns it over a valid/ready result handshake.
- One frame produces one neuron evaluation. This block is the sequential front/back end a layer controller or host interface talks to.

Parameters:
- INPUT_DATA_SIZE, 4, number of input/weight elements per frame (must be >= 1).
- RESOLUTION, 8, bits per element, bias and result; all are signed two's complement.
- SETTLE_CYCLES, 2, cycles from operands becoming valid to result capture (must be >= 2).

Ports:
- clk  in  1  clock; all flops rise-edge triggered.
- reset  in  1  asynchronous, active-high reset.
- s_data  in  RESOLUTION  stream byte (signed).
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader can accept s_data this cycle.
- input_data  out  RESOLUTION*INPUT_DATA_SIZE  flattened inputs; element i occupies [(i+1)*RESOLUTION-1 -: RESOLUTION].
- weight  out  RESOLUTION*INPUT_DATA_SIZE  flattened weights; same packing as input_data.
- bias  out  RESOLUTION  bias operand.
- operands_valid  out  1  input_data, weight and bias form a complete, stable frame.
- neuron_result  in  RESOLUTION  output_neuron from the neuron.
- result_data  out  RESOLUTION  captured neuron result.
- result_valid  out  1  result_data valid.
- result_ready  in  1  downstream accepts result_data.

Behaviour:
- Reset (async, immediate):
  - state=LOAD_IN, element counter=0, settle counter=0.
  - input_data, weight, bias and result_data are all 0.
  - operands_valid=0, result_valid=0, s_ready=1 once reset deasserts.
- A handshake occurs on a rising edge where s_valid && s_ready.
- Frame order is INPUT_DATA_SIZE input bytes (element 0 first), then INPUT_DATA_SIZE weight bytes (element 0 first), then 1 bias byte. Frame length is 2*INPUT_DATA_SIZE+1 bytes; there is no framing sideband.
- States:
  - LOAD_IN: s_ready=1. Each handshake writes s_data into input_data element[cnt] and increments cnt. On the handshake with cnt==INPUT_DATA_SIZE-1: cnt<=0, go to LOAD_W.
  - LOAD_W: s_ready=1. Each handshake writes weight element[cnt]. On the last element: cnt<=0, go to LOAD_B.
  - LOAD_B: s_ready=1. A handshake writes bias, sets operands_valid<=1, settle<=0 and goes to WAIT.
  - WAIT: s_ready=0. settle increments every cycle. On the edge where settle==SETTLE_CYCLES-1: result_data<=neuron_result, result_valid<=1, go to RESULT.
  - RESULT: s_ready=0. result_valid and result_data are held until result_ready is sampled high. On that edge: result_valid<=0, go to LOAD_IN.
- Latency:
  - operands_valid rises the cycle after the bias handshake.
  - result_valid rises exactly SETTLE_CYCLES cycles after operands_valid rises.
  - With the default, the neuron has registered the new operands once and the capture samples that registered value.
- Operand stability:
  - input_data, weight and bias change only on a LOAD_* handshake, so they stay constant through WAIT and RESULT.
  - operands_valid stays 1 through WAIT, RESULT and LOAD_IN until the first handshake of the next frame. It clears on that edge, together with the write of element 0.
- Gaps: s_valid low in any LOAD state stalls with no state change. There is no timeout.
- s_valid while s_ready=0 (WAIT/RESULT): no effect; the byte is not consumed.
- result_ready is ignored outside RESULT. If result_ready is already high on entry to RESULT, result_valid lasts exactly one cycle.
- Arithmetic: none. Bytes are stored bit-exact and sign is preserved (e.g. 8'hFD stays -3).
- Counter width is $clog2(INPUT_DATA_SIZE)+1. When INPUT_DATA_SIZE=1 each LOAD state takes one byte.
- Reset mid-operation, in any state: all registers return to reset values and the partial frame is discarded. The next accepted byte is input element 0.

Test Plan:
- Basic frame (N=4, settle=2): stream 10,20,30,40,1,2,3,4,5 with s_valid held high; tb holds neuron_result=8'sd7 -> input_data=32'h281E140A, weight=32'h04030201, bias=5. operands_valid rises the cycle after the 9th handshake; result_valid rises 2 cycles later with result_data=7; s_ready=0 from the cycle after the bias handshake until the result handshake.
- Stalls: same frame with s_valid low for 3 cycles between every byte -> identical outputs; result_valid rises 2 cycles after operands_valid.
- Backpressure: result_ready low for 5 cycles in RESULT -> result_valid=1 and result_data stable for all 5; s_ready stays 0; one handshake returns to LOAD_IN with s_ready=1.
- Signed data and back-to-back frames: frame 2 with inputs 8'h80, weights 8'hFF, bias 8'hFD, neuron_result=-2 -> fields stored bit-exact; result_data=8'hFE; operands_valid drops on frame 2's first handshake and frame-1 weights persist until overwritten.
- Ignored traffic: s_valid=1 with data 8'h55 throughout WAIT and RESULT -> no register changes; that byte is then accepted as input element 0 of the next frame.
- Reset mid-frame: assert reset after 6 bytes -> all outputs 0 immediately (asynchronous); after release, a fresh 9-byte frame produces correct vectors with no residue from the partial frame.
